ram_loader: RTL
===============

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the stored word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning the address width; depth = 2**ADDR_W (8).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begins a load sequence.
REQ-006 SHALL have port wr_valid  input  1  wr_data is valid.
REQ-007 SHALL have port wr_data  input  DATA_W  word to store.
REQ-008 SHALL have port wr_ready  output  1  loader accepts a word this cycle.
REQ-009 SHALL have port a  input  ADDR_W  read address.
REQ-010 SHALL have port data  output  DATA_W  read data, mem[a].
REQ-011 SHALL have port busy  output  1  high in LOAD.
REQ-012 SHALL have port done  output  1  high in DONE.
REQ-013 SHALL have port wr_count  output  ADDR_W+1  words accepted in the current load, 0..8.
REQ-014 SHALL have port locked  output  1  contents frozen (LOCK_EN only; otherwise tied 0).

Function
REQ-015 SHALL implement the states IDLE, LOAD and DONE, with wr_ready = busy = (state == LOAD) and done = (state == DONE).
REQ-016 In IDLE, start=1 at an edge SHALL move to LOAD with wr_ptr=0 and wr_count=0.
REQ-017 A handshake SHALL occur when wr_valid && wr_ready at an edge: mem[wr_ptr] <= wr_data, wr_ptr+1, wr_count+1.
REQ-018 A handshake at wr_ptr=7 SHALL move to DONE, wrap wr_ptr to 0 and hold wr_count=8, so done=1 in the cycle after the 8th handshake.
REQ-019 wr_valid with wr_ready=0 SHALL be ignored, with no memory or counter change.
REQ-020 Gaps in wr_valid during LOAD SHALL stall the load with no state change and no timeout.
REQ-021 start asserted in LOAD SHALL be ignored.
REQ-022 A simultaneous start and handshake SHALL process the handshake only.
REQ-023 data SHALL equal mem[a] combinationally, with no clock latency.
REQ-024 A read during a write to the same address SHALL return the old value; the new value is visible after the edge.
REQ-025 In DONE, start=1 SHALL behave as in REQ-043/REQ-044.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, wr_ptr=0 and wr_count=0.
REQ-027 rst_n=0 SHALL immediately clear every mem entry to 0, and force wr_ready=0, busy=0, done=0 and locked=0.
REQ-028 While rst_n=0, data SHALL be 0x00 for every a.
REQ-029 Reset asserted mid-load SHALL discard partial contents and return to IDLE.
REQ-030 Release of rst_n SHALL be synchronised by the integrator; the block need not handle release metastability.

Configuration
REQ-040 SHALL have exactly one compile-time macro, RAM_LOADER_LOCK_EN.
REQ-041 With RAM_LOADER_LOCK_EN defined, DONE SHALL be terminal until reset: start is ignored, locked=1 in DONE, and memory is read-only.
REQ-042 Without RAM_LOADER_LOCK_EN, locked SHALL be tied 0.
REQ-043 Without RAM_LOADER_LOCK_EN, start in DONE SHALL move to LOAD with wr_ptr=0 and wr_count=0, and old contents persist until overwritten.
REQ-044 With RAM_LOADER_LOCK_EN defined, start in DONE SHALL leave state=DONE and locked=1.
REQ-045 The port list SHALL be identical in both builds.

Verification
REQ-050 Reset: rst_n=0, then sweep a=0..7 -> data=0x00 for every a, wr_ready=0, done=0, wr_count=0.
REQ-051 Full load: start, then back-to-back 0x11,0x22,...,0x88 -> done=1 the cycle after 0x88; a=3'b010 -> data=0x33; a=3'b011 -> data=0x44; wr_count=8.
REQ-052 Stalled load: wr_valid toggling 1/0 per cycle with 8 words -> wr_count increments only on handshakes; done asserts after 16 cycles; contents correct.
REQ-053 Read-during-write: a=0, write 0x55 as the first word -> data=0x00 in the handshake cycle, 0x55 the next cycle.
REQ-054 Reset mid-load: 3 words written, rst_n pulsed low -> all data=0x00, state IDLE, wr_ready=0.
REQ-055 Reload/lock: in DONE, pulse start -> with RAM_LOADER_LOCK_EN done stays 1 and locked=1; without it busy=1, wr_count=0 and locked=0.

Source files
------------

// File: rtl/ram_loader.sv
// ram_loader: 8-deep register-file RAM filled by a valid/ready write stream, read combinationally.
// Optional macro RAM_LOADER_LOCK_EN makes DONE terminal and freezes contents until reset.
module ram_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              locked
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              hs;

  // Handshake: a word transfers on an edge where wr_valid && wr_ready; wr_ready
  // depends only on state, never on wr_valid.
  assign hs = wr_valid && (state_q == LOAD);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    mem_d      = mem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          wr_count_d = '0;
        end
      end
      LOAD: begin
        // start is ignored here; a concurrent handshake is all that happens.
        if (hs) begin
          mem_d[wr_ptr_q] = wr_data;
          wr_ptr_d        = wr_ptr_q + 1'b1;
          wr_count_d      = wr_count_q + 1'b1;
          if (wr_ptr_q == {ADDR_W{1'b1}}) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
`ifndef RAM_LOADER_LOCK_EN
        if (start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          wr_count_d = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      wr_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_count_q <= wr_count_d;
      mem_q      <= mem_d;
    end
  end

  assign wr_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign wr_count = wr_count_q;
  // Old contents are returned during a same-address write; the new word appears after the edge.
  assign data     = mem_q[a];

`ifdef RAM_LOADER_LOCK_EN
  assign locked = (state_q == DONE);
`else
  assign locked = 1'b0;
`endif

endmodule
